// File: rtl/axil_ls_pkg.sv
// Shared state encodings and AXI response codes for the AXI-Lite low-speed front-end.
package axil_ls_pkg;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_ls_frontend.sv
// AXI4-Lite slave front-end: turns accepted writes/reads into one-cycle backend
// command pulses, returns B/R responses and guards reads with a timeout.
module axil_ls_frontend
  import axil_ls_pkg::*;
#(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned RD_TIMEOUT = 256,
  parameter int unsigned TO_CNT_W   = 9
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              bk_ls_wstart,
  output logic [ADDR_W-1:0] bk_ls_waddr,
  output logic [31:0]       bk_ls_wdata,
  output logic [3:0]        bk_ls_wstrb,
  output logic              bk_ls_rstart,
  output logic [ADDR_W-1:0] bk_ls_raddr,
  input  logic [31:0]       bk_ls_rdata,
  input  logic              bk_ls_rdone
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(RD_TIMEOUT);
  localparam logic                TO_EN    = (RD_TIMEOUT != 0);

  // write path state
  w_state_t            w_state_q, w_state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [31:0]         w_data_q, w_data_d;
  logic [3:0]          w_strb_q, w_strb_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic                wstart_q, wstart_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;

  // read path state
  r_state_t            r_state_q, r_state_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                stale_q, stale_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rstart_q, rstart_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;

  // arbiter
  logic                last_rd_q, last_rd_d;
  logic                w_req, r_req, w_gnt, r_gnt;

  // Issue arbitration; the last-grant flag only moves when both paths contend,
  // so back-to-back ties alternate regardless of uncontended issues in between.
  always_comb begin
    w_req     = (w_state_q == W_IDLE) && aw_held_q && w_held_q;
    r_req     = (r_state_q == R_ISSUE);
    w_gnt     = w_req && (!r_req || last_rd_q);
    r_gnt     = r_req && (!w_req || !last_rd_q);
    last_rd_d = last_rd_q;
    if (w_req && r_req) last_rd_d = r_gnt;
  end

  // Write path: independent AW/W capture, single wstart pulse, then B response.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    wstart_d  = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_awaddr;
        end
        if (s_wvalid && wready_q) begin
          w_held_d = 1'b1;
          w_data_d = s_wdata;
          w_strb_d = s_wstrb;
        end
        if (w_gnt) begin
          w_state_d = W_ISSUE;
          wstart_d  = 1'b1;
          waddr_d   = aw_addr_q;
          wdata_d   = w_data_q;
          wstrb_d   = w_strb_q;
        end
      end
      W_ISSUE: begin
        w_state_d = W_RESP;
        bvalid_d  = 1'b1;
      end
      W_RESP: begin
        if (s_bready && bvalid_q) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Read path: capture AR, pulse rstart on grant, wait for rdone or timeout.
  // An rdone arriving while stale is set belongs to a timed-out read and is
  // swallowed, even if a newer read is already waiting.
  always_comb begin
    r_state_d = r_state_q;
    ar_addr_d = ar_addr_q;
    to_cnt_d  = to_cnt_q;
    stale_d   = stale_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rstart_d  = 1'b0;
    raddr_d   = raddr_q;
    if (bk_ls_rdone && stale_q) stale_d = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_arvalid && arready_q) begin
          r_state_d = R_ISSUE;
          ar_addr_d = s_araddr;
        end
      end
      R_ISSUE: begin
        if (r_gnt) begin
          r_state_d = R_WAIT;
          rstart_d  = 1'b1;
          raddr_d   = ar_addr_q;
          to_cnt_d  = '0;
        end
      end
      R_WAIT: begin
        if (bk_ls_rdone && !stale_q) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rdata_d   = bk_ls_rdata;
          rresp_d   = RESP_OKAY;
        end else if (TO_EN && (to_cnt_q == TO_LIMIT)) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          stale_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
      end
      R_RESP: begin
        if (s_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      wstart_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      r_state_q <= R_IDLE;
      ar_addr_q <= '0;
      to_cnt_q  <= '0;
      stale_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rstart_q  <= 1'b0;
      raddr_q   <= '0;
      last_rd_q <= 1'b1;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      wstart_q  <= wstart_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      r_state_q <= r_state_d;
      ar_addr_q <= ar_addr_d;
      to_cnt_q  <= to_cnt_d;
      stale_q   <= stale_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rstart_q  <= rstart_d;
      raddr_q   <= raddr_d;
      last_rd_q <= last_rd_d;
    end
  end

  assign s_awready    = awready_q;
  assign s_wready     = wready_q;
  assign s_bvalid     = bvalid_q;
  assign s_bresp      = RESP_OKAY;
  assign s_arready    = arready_q;
  assign s_rvalid     = rvalid_q;
  assign s_rdata      = rdata_q;
  assign s_rresp      = rresp_q;
  assign bk_ls_wstart = wstart_q;
  assign bk_ls_waddr  = waddr_q;
  assign bk_ls_wdata  = wdata_q;
  assign bk_ls_wstrb  = wstrb_q;
  assign bk_ls_rstart = rstart_q;
  assign bk_ls_raddr  = raddr_q;

endmodule

// File: tb/tb_axil_ls_frontend.sv
// Directed bench for axil_ls_frontend: cycle-by-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_axil_ls_frontend;

  localparam int unsigned AW = 15;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s_awvalid, s_awready;
  logic [AW-1:0] s_awaddr;
  logic          s_wvalid, s_wready;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_bvalid, s_bready;
  logic [1:0]    s_bresp;
  logic          s_arvalid, s_arready;
  logic [AW-1:0] s_araddr;
  logic          s_rvalid, s_rready;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic          bk_ls_wstart;
  logic [AW-1:0] bk_ls_waddr;
  logic [31:0]   bk_ls_wdata;
  logic [3:0]    bk_ls_wstrb;
  logic          bk_ls_rstart;
  logic [AW-1:0] bk_ls_raddr;
  logic [31:0]   bk_ls_rdata;
  logic          bk_ls_rdone;

  always #5 clk = ~clk;

  axil_ls_frontend #(
    .ADDR_W    (AW),
    .RD_TIMEOUT(16),
    .TO_CNT_W  (5)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rstn),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .s_awaddr    (s_awaddr),
    .s_wvalid    (s_wvalid),
    .s_wready    (s_wready),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .s_bresp     (s_bresp),
    .s_arvalid   (s_arvalid),
    .s_arready   (s_arready),
    .s_araddr    (s_araddr),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .bk_ls_wstart(bk_ls_wstart),
    .bk_ls_waddr (bk_ls_waddr),
    .bk_ls_wdata (bk_ls_wdata),
    .bk_ls_wstrb (bk_ls_wstrb),
    .bk_ls_rstart(bk_ls_rstart),
    .bk_ls_raddr (bk_ls_raddr),
    .bk_ls_rdata (bk_ls_rdata),
    .bk_ls_rdone (bk_ls_rdone)
  );

  typedef struct packed {
    logic          awvalid;
    logic [AW-1:0] awaddr;
    logic          wvalid;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          bready;
    logic          arvalid;
    logic [AW-1:0] araddr;
    logic          rready;
    logic          rdone;
    logic [31:0]   rdata;
  } ins_t;

  typedef struct packed {
    logic          awready;
    logic          wready;
    logic          bvalid;
    logic          wstart;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          arready;
    logic          rstart;
    logic [AW-1:0] raddr;
    logic          rvalid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic [1:0]    bresp;
  } outs_t;

  typedef struct {
    ins_t  stim;
    outs_t exp;
  } vec_t;

  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wstart_cnt = 0;
  int   w0;
  int   lat;

  always @(negedge clk) if (bk_ls_wstart) wstart_cnt++;

  function automatic ins_t mi(logic awv, logic [AW-1:0] awa, logic wv, logic [31:0] wd,
                              logic [3:0] ws, logic br, logic arv, logic [AW-1:0] ara,
                              logic rr, logic rdn, logic [31:0] rdt);
    ins_t v;
    v.awvalid = awv; v.awaddr = awa; v.wvalid = wv; v.wdata = wd; v.wstrb = ws;
    v.bready = br; v.arvalid = arv; v.araddr = ara; v.rready = rr; v.rdone = rdn;
    v.rdata = rdt;
    return v;
  endfunction

  function automatic outs_t mo(logic awr, logic wr, logic bv, logic wst, logic [AW-1:0] wa,
                               logic [31:0] wd, logic [3:0] wsb, logic arr, logic rst,
                               logic [AW-1:0] ra, logic rv, logic [31:0] rdt, logic [1:0] rrs);
    outs_t o;
    o.awready = awr; o.wready = wr; o.bvalid = bv; o.wstart = wst; o.waddr = wa;
    o.wdata = wd; o.wstrb = wsb; o.arready = arr; o.rstart = rst; o.raddr = ra;
    o.rvalid = rv; o.rdata = rdt; o.rresp = rrs; o.bresp = 2'b00;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.awready = s_awready; o.wready = s_wready; o.bvalid = s_bvalid;
    o.wstart = bk_ls_wstart; o.waddr = bk_ls_waddr; o.wdata = bk_ls_wdata;
    o.wstrb = bk_ls_wstrb; o.arready = s_arready; o.rstart = bk_ls_rstart;
    o.raddr = bk_ls_raddr; o.rvalid = s_rvalid; o.rdata = s_rdata;
    o.rresp = s_rresp; o.bresp = s_bresp;
    return o;
  endfunction

  task automatic drive(input ins_t v);
    s_awvalid = v.awvalid; s_awaddr = v.awaddr; s_wvalid = v.wvalid;
    s_wdata = v.wdata; s_wstrb = v.wstrb; s_bready = v.bready;
    s_arvalid = v.arvalid; s_araddr = v.araddr; s_rready = v.rready;
    bk_ls_rdone = v.rdone; bk_ls_rdata = v.rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input outs_t act, input outs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // tie on the first cycle after reset: write wins, read issues next;
    // the second tie goes to read; the second write forwards wstrb = 0
    tbl[0].stim  = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0].exp   = mo(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1].stim  = mi(1, 15'h0010, 1, 32'hA5A5_0001, 4'hF, 0, 1, 15'h0100, 0, 0, 0);
    tbl[1].exp   = mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2].stim  = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2].exp   = mo(0, 0, 0, 1, 15'h0010, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0, 0, 0);
    tbl[3].stim  = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3].exp   = mo(0, 0, 1, 0, 15'h0010, 32'hA5A5_0001, 4'hF, 0, 1, 15'h0100, 0, 0, 0);
    tbl[4].stim  = mi(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[4].exp   = mo(1, 1, 0, 0, 15'h0010, 32'hA5A5_0001, 4'hF, 0, 0, 15'h0100, 0, 0, 0);
    tbl[5].stim  = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222);
    tbl[5].exp   = mo(1, 1, 0, 0, 15'h0010, 32'hA5A5_0001, 4'hF, 0, 0, 15'h0100, 1, 32'h1111_2222, 0);
    tbl[6].stim  = mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[6].exp   = mo(1, 1, 0, 0, 15'h0010, 32'hA5A5_0001, 4'hF, 1, 0, 15'h0100, 0, 32'h1111_2222, 0);
    tbl[7].stim  = mi(1, 15'h0020, 1, 32'h0000_0002, 4'h0, 0, 1, 15'h0200, 0, 0, 0);
    tbl[7].exp   = mo(0, 0, 0, 0, 15'h0010, 32'hA5A5_0001, 4'hF, 0, 0, 15'h0100, 0, 32'h1111_2222, 0);
    tbl[8].stim  = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8].exp   = mo(0, 0, 0, 0, 15'h0010, 32'hA5A5_0001, 4'hF, 0, 1, 15'h0200, 0, 32'h1111_2222, 0);
    tbl[9].stim  = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9].exp   = mo(0, 0, 0, 1, 15'h0020, 32'h0000_0002, 4'h0, 0, 0, 15'h0200, 0, 32'h1111_2222, 0);
    tbl[10].stim = mi(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h3333_4444);
    tbl[10].exp  = mo(0, 0, 1, 0, 15'h0020, 32'h0000_0002, 4'h0, 0, 0, 15'h0200, 1, 32'h3333_4444, 0);
    tbl[11].stim = mi(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    tbl[11].exp  = mo(1, 1, 0, 0, 15'h0020, 32'h0000_0002, 4'h0, 1, 0, 15'h0200, 0, 32'h3333_4444, 0);

    rstn = 1'b0;
    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) tick();
    chk_vec("reset_state", sample(), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].stim);
      tick();
      chk_vec($sformatf("vec%0d", i), sample(), tbl[i].exp);
    end
    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // W three cycles ahead of AW, then B back-pressure blocking the next AW
    s_wvalid = 1; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
    tick();
    s_wvalid = 0;
    chk("A_wready_low", {31'd0, s_wready}, 32'd0);
    chk("A_awready_high", {31'd0, s_awready}, 32'd1);
    w0 = wstart_cnt;
    tick(); tick();
    s_awvalid = 1; s_awaddr = 15'h7FFC;
    tick();
    s_awvalid = 0;
    chk("A_no_early_wstart", {31'd0, bk_ls_wstart}, 32'd0);
    tick();
    chk("A_wstart", {31'd0, bk_ls_wstart}, 32'd1);
    chk("A_waddr", {17'd0, bk_ls_waddr}, 32'h7FFC);
    chk("A_wdata", bk_ls_wdata, 32'h1234_5678);
    tick();
    chk("A_bvalid", {31'd0, s_bvalid}, 32'd1);
    s_awvalid = 1; s_awaddr = 15'h0044;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("A_bhold%0d", i), {30'd0, s_bvalid, s_awready}, 32'd2);
    end
    s_bready = 1;
    tick();
    s_bready = 0;
    chk("A_bvalid_drop", {31'd0, s_bvalid}, 32'd0);
    chk("A_single_wstart", wstart_cnt - w0, 32'd1);
    tick();
    s_awvalid = 0;
    s_wvalid = 1; s_wdata = 32'h0000_0055; s_wstrb = 4'h3;
    tick();
    s_wvalid = 0;
    tick();
    chk("A2_wstart", {31'd0, bk_ls_wstart}, 32'd1);
    chk("A2_waddr", {17'd0, bk_ls_waddr}, 32'h0044);
    chk("A2_wstrb", {28'd0, bk_ls_wstrb}, 32'h3);
    tick();
    s_bready = 1;
    tick();
    s_bready = 0;

    // read with rdone five cycles after rstart and delayed rready
    s_arvalid = 1; s_araddr = 15'h0100;
    tick();
    s_arvalid = 0;
    tick();
    chk("B_rstart", {31'd0, bk_ls_rstart}, 32'd1);
    chk("B_raddr", {17'd0, bk_ls_raddr}, 32'h0100);
    repeat (5) tick();
    bk_ls_rdone = 1; bk_ls_rdata = 32'hCAFE_F00D;
    tick();
    bk_ls_rdone = 0; bk_ls_rdata = 32'h0;
    chk("B_rvalid", {31'd0, s_rvalid}, 32'd1);
    chk("B_rdata", s_rdata, 32'hCAFE_F00D);
    chk("B_rresp", {30'd0, s_rresp}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("B_rhold%0d", i), {31'd0, s_rvalid}, 32'd1);
      chk($sformatf("B_rdata_stable%0d", i), s_rdata, 32'hCAFE_F00D);
    end
    s_rready = 1;
    tick();
    s_rready = 0;
    chk("B_rvalid_drop", {31'd0, s_rvalid}, 32'd0);

    // timeout after 16 cycles, then stale rdone swallowed by the next read
    s_arvalid = 1; s_araddr = 15'h0300;
    tick();
    s_arvalid = 0;
    tick();
    chk("C_rstart", {31'd0, bk_ls_rstart}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (s_rvalid) begin
        lat = i;
        break;
      end
    end
    chk("C_timeout_latency", lat, 32'd17);
    chk("C_rresp_slverr", {30'd0, s_rresp}, 32'd2);
    chk("C_rdata_zero", s_rdata, 32'd0);
    s_rready = 1;
    tick();
    s_rready = 0;
    s_arvalid = 1; s_araddr = 15'h0304;
    tick();
    s_arvalid = 0;
    tick();
    chk("C2_rstart", {31'd0, bk_ls_rstart}, 32'd1);
    tick();
    bk_ls_rdone = 1; bk_ls_rdata = 32'hDEAD_BEEF;
    tick();
    bk_ls_rdone = 0; bk_ls_rdata = 32'h0;
    chk("C2_stale_dropped", {31'd0, s_rvalid}, 32'd0);
    tick();
    bk_ls_rdone = 1; bk_ls_rdata = 32'h0BAD_CAFE;
    tick();
    bk_ls_rdone = 0; bk_ls_rdata = 32'h0;
    chk("C2_rvalid", {31'd0, s_rvalid}, 32'd1);
    chk("C2_rdata", s_rdata, 32'h0BAD_CAFE);
    chk("C2_rresp", {30'd0, s_rresp}, 32'd0);
    s_rready = 1;
    tick();
    s_rready = 0;

    // reset while a read waits and a W beat is held
    s_arvalid = 1; s_araddr = 15'h0400;
    tick();
    s_arvalid = 0;
    tick();
    chk("D_rstart", {31'd0, bk_ls_rstart}, 32'd1);
    s_wvalid = 1; s_wdata = 32'h0000_0077; s_wstrb = 4'hF;
    tick();
    s_wvalid = 0;
    rstn = 0;
    tick();
    chk_vec("D_reset_outputs", sample(), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rstn = 1;
    tick();
    bk_ls_rdone = 1; bk_ls_rdata = 32'h9999_9999;
    tick();
    bk_ls_rdone = 0; bk_ls_rdata = 32'h0;
    chk("D_rdone_ignored", {31'd0, s_rvalid}, 32'd0);
    tick();
    chk("D_rdone_ignored2", {30'd0, s_rvalid, bk_ls_rstart}, 32'd0);
    s_awvalid = 1; s_awaddr = 15'h0008;
    s_wvalid = 1; s_wdata = 32'h0000_ABCD; s_wstrb = 4'hF;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    tick();
    chk("D_wstart", {31'd0, bk_ls_wstart}, 32'd1);
    chk("D_waddr", {17'd0, bk_ls_waddr}, 32'h0008);
    chk("D_wdata", bk_ls_wdata, 32'h0000_ABCD);
    tick();
    chk("D_bvalid", {31'd0, s_bvalid}, 32'd1);
    chk("D_bresp", {30'd0, s_bresp}, 32'd0);
    s_bready = 1;
    tick();
    s_bready = 0;
    chk("D_bvalid_drop", {31'd0, s_bvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
